// File: rtl/uplink_pkg.sv
// uplink_pkg: constants, state enum and CRC helper shared by the uplink transmit and receive chains
package uplink_pkg;
  localparam logic [15:0] SYNC_WORD = 16'hD391;
  localparam logic [6:0] LFSR_SEED = 7'h7F;
  localparam int LFSR_TAP_HI = 6;
  localparam int LFSR_TAP_LO = 3;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  typedef enum logic [1:0] {HUNT, PAYLOAD, CRC} state_t;
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/uplink_dewhitener.sv
// uplink_dewhitener: x^7+x^4+1 Fibonacci whitening LFSR with load/advance and XOR output
module uplink_dewhitener
  import uplink_pkg::*;
#(
  parameter logic [6:0] SEED = LFSR_SEED
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic advance,
  input  logic din,
  output logic dout
);
  logic [6:0] lfsr;
  assign dout = din ^ lfsr[LFSR_TAP_HI];
  always_ff @(posedge clock) begin
    if (reset || load) lfsr <= SEED;
    else if (advance) lfsr <= {lfsr[5:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
  end
endmodule

// File: rtl/uplink_packet_decoder.sv
// uplink_packet_decoder: DBPSK differential decode, sync hunt, dewhitening and byte assembly (CRC check with UPLINK_CRC_CHECK_EN)
module uplink_packet_decoder #(
  parameter logic [15:0] SYNC_WORD = uplink_pkg::SYNC_WORD,
  parameter int PAYLOAD_BYTES = 64,
  parameter logic [6:0] LFSR_SEED = uplink_pkg::LFSR_SEED
) (
  input  logic clock,
  input  logic reset,
  input  logic trigger,
  input  logic bit_valid,
  input  logic phase_bit,
  input  logic fifo_full,
  output logic [7:0] out_data,
  output logic fifo_we,
  output logic in_packet,
  output logic pkt_done,
`ifdef UPLINK_CRC_CHECK_EN
  output logic crc_ok,
`endif
  output logic overflow
);
  import uplink_pkg::*;
  state_t state;
  logic prev_phase, d, b, sync_hit, last, fin;
  logic [14:0] sync_sr;
  logic [15:0] sync_nx;
  logic [6:0] byte_sr;
  logic [7:0] byte_nx, byte_cnt;
  logic [2:0] bit_cnt;
  assign d = phase_bit ^ prev_phase;
  assign sync_nx = {sync_sr, d};
  assign sync_hit = state == HUNT && sync_nx == SYNC_WORD;
  assign byte_nx = {byte_sr, b};
  assign last = byte_cnt == 8'(PAYLOAD_BYTES - 1);
`ifdef UPLINK_CRC_CHECK_EN
  logic [7:0] crc;
  assign fin = state == CRC;
`else
  assign fin = last;
`endif
  uplink_dewhitener #(.SEED(LFSR_SEED)) dewhite (
    .clock(clock),
    .reset(reset),
    .load(trigger && bit_valid && sync_hit),
    .advance(trigger && bit_valid && state != HUNT),
    .din(d),
    .dout(b)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HUNT;
      prev_phase <= 1'b0;
      sync_sr <= '0;
      byte_sr <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      out_data <= '0;
      fifo_we <= 1'b0;
      in_packet <= 1'b0;
      pkt_done <= 1'b0;
      overflow <= 1'b0;
`ifdef UPLINK_CRC_CHECK_EN
      crc <= '0;
      crc_ok <= 1'b0;
`endif
    end else begin
      fifo_we <= 1'b0;
      pkt_done <= 1'b0;
`ifdef UPLINK_CRC_CHECK_EN
      crc_ok <= 1'b0;
`endif
      if (!trigger) begin
        state <= HUNT;
        in_packet <= 1'b0;
        prev_phase <= 1'b0;
        sync_sr <= '0;
        byte_sr <= '0;
        bit_cnt <= '0;
      end else if (bit_valid) begin
        prev_phase <= phase_bit;
        if (state == HUNT) begin
          sync_sr <= sync_nx[14:0];
          if (sync_hit) begin
            state <= PAYLOAD;
            in_packet <= 1'b1;
            bit_cnt <= '0;
            byte_cnt <= '0;
`ifdef UPLINK_CRC_CHECK_EN
            crc <= '0;
`endif
          end
        end else begin
          byte_sr <= byte_nx[6:0];
          bit_cnt <= bit_cnt + 3'd1;
`ifdef UPLINK_CRC_CHECK_EN
          if (state == PAYLOAD) crc <= crc8_step(crc, b);
`endif
          if (bit_cnt == 3'd7) begin
            if (state == PAYLOAD) begin
              out_data <= byte_nx;
              fifo_we <= !fifo_full;
              overflow <= overflow | fifo_full;
              byte_cnt <= byte_cnt + 8'd1;
            end
            // sync_sr starts clean so tail bits of this packet cannot fake a sync
            if (fin) begin
              pkt_done <= 1'b1;
              in_packet <= 1'b0;
              state <= HUNT;
              sync_sr <= '0;
`ifdef UPLINK_CRC_CHECK_EN
              crc_ok <= byte_nx == crc;
            end else if (last) begin
              state <= CRC;
`endif
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_uplink_packet_decoder.sv
// tb_uplink_packet_decoder: directed vector table plus abort, sticky-overflow and sparse/reset sequences
module tb_uplink_packet_decoder;
  localparam int PB = 64;
  logic clock = 1'b0, reset = 1'b1, trigger = 1'b0, bit_valid = 1'b0, phase_bit = 1'b0, fifo_full = 1'b0;
  logic [7:0] out_data;
  logic fifo_we, in_packet, pkt_done, overflow;
`ifdef UPLINK_CRC_CHECK_EN
  logic crc_ok, last_crc_ok = 1'b0;
`endif
  int checks = 0, errors = 0;
  logic tx_phase = 1'b0;
  logic [6:0] tx_lfsr = 7'h7F;
  logic [7:0] wr_log[$];
  int done_total = 0;

  typedef struct {
    logic [15:0] sync;
    int nbytes;
    int full_idx;
    int exp_writes;
    int exp_done;
    int exp_ovf;
    int exp_inpkt;
  } vec_t;
  vec_t vecs[4];

  uplink_packet_decoder dut (
    .clock(clock),
    .reset(reset),
    .trigger(trigger),
    .bit_valid(bit_valid),
    .phase_bit(phase_bit),
    .fifo_full(fifo_full),
    .out_data(out_data),
    .fifo_we(fifo_we),
    .in_packet(in_packet),
    .pkt_done(pkt_done),
`ifdef UPLINK_CRC_CHECK_EN
    .crc_ok(crc_ok),
`endif
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (fifo_we) wr_log.push_back(out_data);
    if (pkt_done) begin
      done_total++;
`ifdef UPLINK_CRC_CHECK_EN
      last_crc_ok = crc_ok;
`endif
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bytes(input string name, input int start, input int n, input int skip);
    int k = start;
    int bad = -1;
    int act = -1;
    for (int i = 0; i < n; i++) begin
      if (i != skip) begin
        if (bad < 0 && (k >= wr_log.size() || wr_log[k] !== 8'(i))) begin
          bad = i;
          act = (k < wr_log.size()) ? int'(wr_log[k]) : -1;
        end
        k++;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: payload byte %0d got %0d expected %0d", name, bad, act, bad);
    end
  endtask

  function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ v[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  task automatic send_bit(input logic u, input int gap);
    tx_phase = tx_phase ^ u;
    bit_valid = 1'b1;
    phase_bit = tx_phase;
    @(negedge clock);
    bit_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap, input logic full, input logic whiten);
    fifo_full = full;
    for (int i = 7; i >= 0; i--) begin
      logic w;
      w = whiten & tx_lfsr[6];
      if (whiten) tx_lfsr = {tx_lfsr[5:0], tx_lfsr[6] ^ tx_lfsr[3]};
      send_bit(v[i] ^ w, gap);
    end
    fifo_full = 1'b0;
  endtask

  task automatic send_sync(input logic [15:0] s, input int gap);
    send_byte(s[15:8], gap, 1'b0, 1'b0);
    send_byte(s[7:0], gap, 1'b0, 1'b0);
    tx_lfsr = 7'h7F;
  endtask

  task automatic send_payload(input int n, input int gap, input int full_idx, input logic [7:0] flip);
    logic [7:0] crc = 8'h00;
    for (int i = 0; i < n; i++) begin
      send_byte(8'(i), gap, i == full_idx, 1'b1);
      crc = crc_byte(crc, 8'(i));
    end
`ifdef UPLINK_CRC_CHECK_EN
    if (n == PB) send_byte(crc ^ flip, gap, 1'b0, 1'b1);
`else
    if (flip != 8'h00 && crc == 8'h00) $display("note: crc flip ignored");
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trigger = 1'b0;
    bit_valid = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    trigger = 1'b1;
    tx_phase = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int w0, d0;
    vecs[0] = '{16'hD391, PB, -1, PB, 1, 0, 1};
    vecs[1] = '{16'hD390, 8, -1, 0, 0, 0, 0};
    vecs[2] = '{16'hD391, PB, 5, PB - 1, 1, 1, 1};
    vecs[3] = '{16'hD393, 8, -1, 0, 0, 0, 0};
    @(negedge clock);
    do_reset();
    check("reset_outputs", int'({out_data, fifo_we, in_packet, pkt_done, overflow}), 0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      w0 = wr_log.size();
      d0 = done_total;
      send_sync(vecs[v].sync, 0);
      check($sformatf("v%0d_in_packet_after_sync", v), int'(in_packet), vecs[v].exp_inpkt);
      send_payload(vecs[v].nbytes, 0, vecs[v].full_idx, 8'h00);
      repeat (3) @(negedge clock);
      check($sformatf("v%0d_writes", v), wr_log.size() - w0, vecs[v].exp_writes);
      if (vecs[v].exp_writes > 0) check_bytes($sformatf("v%0d_data", v), w0, vecs[v].nbytes, vecs[v].full_idx);
      check($sformatf("v%0d_pkt_done", v), done_total - d0, vecs[v].exp_done);
      check($sformatf("v%0d_overflow", v), int'(overflow), vecs[v].exp_ovf);
      check($sformatf("v%0d_in_packet_end", v), int'(in_packet), 0);
`ifdef UPLINK_CRC_CHECK_EN
      if (vecs[v].exp_done > 0) check($sformatf("v%0d_crc_ok", v), int'(last_crc_ok), 1);
`endif
    end

    // overflow must survive a later clean packet
    do_reset();
    send_sync(16'hD391, 0);
    send_payload(PB, 0, 5, 8'h00);
    repeat (2) @(negedge clock);
    w0 = wr_log.size();
    d0 = done_total;
    send_sync(16'hD391, 0);
    send_payload(PB, 0, -1, 8'h00);
    repeat (3) @(negedge clock);
    check("sticky_overflow", int'(overflow), 1);
    check("sticky_writes", wr_log.size() - w0, PB);
    check_bytes("sticky_data", w0, PB, -1);
    check("sticky_done", done_total - d0, 1);

    // abort mid-packet, including a half-received byte
    do_reset();
    w0 = wr_log.size();
    d0 = done_total;
    send_sync(16'hD391, 0);
    send_payload(20, 0, -1, 8'h00);
    check("abort_in_packet_mid", int'(in_packet), 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    trigger = 1'b0;
    tx_phase = 1'b0;
    @(negedge clock);
    check("abort_in_packet", int'(in_packet), 0);
    trigger = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_writes", wr_log.size() - w0, 20);
    check("abort_no_done", done_total - d0, 0);
    w0 = wr_log.size();
    d0 = done_total;
    send_sync(16'hD391, 0);
    send_payload(PB, 0, -1, 8'h00);
    repeat (3) @(negedge clock);
    check("resend_writes", wr_log.size() - w0, PB);
    check_bytes("resend_data", w0, PB, -1);
    check("resend_done", done_total - d0, 1);

    // sparse bits, reset at byte 30, then a fresh packet
    do_reset();
    send_sync(16'hD391, 6);
    send_payload(30, 6, 3, 8'h00);
    check("sparse_overflow_before_reset", int'(overflow), 1);
    reset = 1'b1;
    @(negedge clock);
    check("sparse_reset_outputs", int'({out_data, fifo_we, in_packet, pkt_done, overflow}), 0);
    do_reset();
    w0 = wr_log.size();
    d0 = done_total;
    send_sync(16'hD391, 6);
    send_payload(PB, 6, -1, 8'h00);
    repeat (8) @(negedge clock);
    check("sparse_writes", wr_log.size() - w0, PB);
    check_bytes("sparse_data", w0, PB, -1);
    check("sparse_done", done_total - d0, 1);
    check("sparse_overflow", int'(overflow), 0);

`ifdef UPLINK_CRC_CHECK_EN
    do_reset();
    w0 = wr_log.size();
    d0 = done_total;
    send_sync(16'hD391, 0);
    send_payload(PB, 0, -1, 8'h01);
    repeat (3) @(negedge clock);
    check("crc_bad_writes", wr_log.size() - w0, PB);
    check("crc_bad_done", done_total - d0, 1);
    check("crc_bad_crc_ok", int'(last_crc_ok), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uplink_packet_decoder.md
Name: uplink_packet_decoder

Overview:
- Receive-side counterpart of the uplink transmit chain: packet encoder, whitening and DBPSK modulator.
- Consumes the demodulated phase bit stream, undoes the differential coding and hunts for the sync word.
- Dewhitens the payload, reassembles bytes MSB-first and writes them into a byte FIFO.
- Used as an on-FPGA loopback checker and as the core of the reader-side uplink receiver.

Parameters:
- SYNC_WORD, 16'hD391, sync pattern matched on differentially decoded, unwhitened bits.
- PAYLOAD_BYTES, 64, payload bytes per packet (1..255).
- LFSR_SEED, 7'h7F, whitening LFSR seed loaded at the first payload bit.

Ports:
- clock  in  1  bit-rate-domain clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- trigger  in  1  receive enable; low forces HUNT and clears the bit pipeline.
- bit_valid  in  1  one-cycle strobe marking a new phase bit.
- phase_bit  in  1  demodulated DBPSK phase bit, sampled when bit_valid=1.
- fifo_full  in  1  downstream FIFO full.
- out_data  out  8  assembled payload byte.
- fifo_we  out  1  one-cycle write strobe for out_data.
- in_packet  out  1  high from sync detect until the last payload byte is written.
- pkt_done  out  1  one-cycle pulse after the last payload byte.
- overflow  out  1  sticky; set when a byte is dropped on fifo_full; cleared only by reset.

Behaviour:
- Reset: all outputs 0, state HUNT, prev_phase=0, shift register 0, LFSR=LFSR_SEED.
- All actions occur only on cycles with bit_valid=1 and trigger=1, except reset, trigger abort and output pulses.
- Differential decode: d = phase_bit XOR prev_phase; prev_phase <= phase_bit on every valid bit, in all states.
- The first valid bit after reset or trigger rise has prev_phase=0.
- HUNT:
  - Shift d into 16-bit sync_sr (LSB in).
  - When the updated sync_sr == SYNC_WORD: go to PAYLOAD, in_packet=1, load LFSR=LFSR_SEED, bit_cnt=0, byte_cnt=0.
  - Exact match only.
- PAYLOAD:
  - Dewhitened bit b = d XOR lfsr[6].
  - Advance the LFSR: x^7+x^4+1, Fibonacci, shift left, new lsb = lfsr[6]^lfsr[3].
  - Shift b into byte_sr MSB-first and increment the 3-bit bit_cnt.
  - On the 8th bit, write the byte:
    - Registered: out_data = full byte, fifo_we=1 for exactly one cycle, 1 cycle after the bit_valid cycle.
    - If fifo_full=1 on that cycle: fifo_we stays 0, the byte is dropped and overflow<=1.
    - byte_cnt increments either way.
  - When byte_cnt reaches PAYLOAD_BYTES: pkt_done pulses in the same cycle as the last fifo_we slot, in_packet<=0, state goes to HUNT, and sync_sr is cleared.
- Abort: trigger=0 in any state gives HUNT, in_packet=0 and no pkt_done on the next edge. A partial byte is discarded; overflow is retained.
- Bits arriving back-to-back (bit_valid high every cycle) must be sustained without loss.
- Reset mid-packet: identical to the power-up reset state.

Optional Feature:
- Macro: UPLINK_CRC_CHECK_EN.
- Defined:
  - A CRC state follows the payload. It receives one extra dewhitened byte, with the LFSR continuing.
  - CRC-8, poly 0x07, init 0x00, computed over the dewhitened payload bits MSB-first.
  - The CRC byte is not written to the FIFO.
  - pkt_done fires after the CRC byte, together with a new output crc_ok (1 if match); crc_ok is valid only while pkt_done=1, else 0.
- Undefined: no CRC state and no crc_ok port; pkt_done follows the last payload byte.

Decomposition:
- Shared package uplink_pkg:
  - SYNC_WORD default, LFSR polynomial taps, LFSR_SEED, CRC8_POLY.
  - State enum {HUNT, PAYLOAD, CRC}.
  - This package is shared with the transmit-side whitening and packet encoder.
- One sub-module, uplink_dewhitener: LFSR with load/advance controls and the XOR output, reusable by whitening verification.

Test Plan:
- Clean packet: send phase bits encoding 16'hD391, then 64 whitened bytes 0x00..0x3F, continuous bit_valid.
  - Expect 64 fifo_we pulses with out_data 0x00..0x3F in order, one pkt_done, and in_packet high throughout.
- Sync near-miss: send 16'hD390, then valid payload.
  - Expect no fifo_we and in_packet=0.
- Backpressure: fifo_full=1 during byte 5 only.
  - Expect 63 writes with byte 0x05 missing, overflow=1 (sticky), and pkt_done still asserted.
- Abort: drop trigger after 20 bytes, then resend a full packet.
  - Expect no pkt_done for the first packet and a correct second packet of 64 bytes.
- Sparse bit_valid: one valid bit every 7 cycles, with a reset asserted at byte 30 and then a fresh packet.
  - Expect outputs zero after reset and a correct fresh packet.
- UPLINK_CRC_CHECK_EN: send a correct CRC, then a CRC with one bit flipped.
  - Expect crc_ok=1 with pkt_done for the first packet and crc_ok=0 for the second.
  - Expect 64 writes each, with no CRC byte written.
